// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler
//   Sequences one frame of drawing. On a frame tick the background drawer
//   runs first. Then each sprite drawer that is requesting gets one job,
//   picked round-robin. A watchdog aborts any drawer job that hangs. The
//   granted drawer's pixel stream is registered onto the frame-buffer port.
//
// Ports
//   clock, resetn          rising-edge clock, synchronous active-low reset
//   frame_tick             one-cycle request for a new frame
//   bg_start / bg_finished background drawer handshake (pulse out, level in)
//   bg_x/y/colour/plot     background pixel stream
//   cl_req                 per-sprite draw request (level)
//   cl_start / cl_finished per-sprite handshake (one-hot pulse out, level in)
//   cl_x/y/colour/plot     packed sprite pixel streams, index i at [i*W +: W]
//   vga_x/y/colour/plot    registered pixel port to the frame buffer
//   busy, frame_done       status: not idle / end-of-frame pulse
//   overrun, timeout_err   sticky error flags, cleared only by reset
//
// state   | meaning
// IDLE    | waiting for frame_tick
// BG_GO   | pulse bg_start, clear watchdog
// BG_WAIT | stream background pixels until bg_finished or timeout
// SCAN    | pick next unserved requester round-robin, or finish the frame
// CL_GO   | pulse cl_start[sel], clear watchdog
// CL_WAIT | stream sprite sel pixels until cl_finished[sel] or timeout
// DONE    | pulse frame_done
module frame_draw_scheduler #(
   parameter int X_W     = 8,
   parameter int Y_W     = 7,
   parameter int C_W     = 3,
   parameter int N       = 4,
   parameter int TIMEOUT = 20000
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             frame_tick,
   output logic             bg_start,
   input  logic             bg_finished,
   input  logic [X_W-1:0]   bg_x,
   input  logic [Y_W-1:0]   bg_y,
   input  logic [C_W-1:0]   bg_colour,
   input  logic             bg_plot,
   input  logic [N-1:0]     cl_req,
   output logic [N-1:0]     cl_start,
   input  logic [N-1:0]     cl_finished,
   input  logic [N*X_W-1:0] cl_x,
   input  logic [N*Y_W-1:0] cl_y,
   input  logic [N*C_W-1:0] cl_colour,
   input  logic [N-1:0]     cl_plot,
   output logic [X_W-1:0]   vga_x,
   output logic [Y_W-1:0]   vga_y,
   output logic [C_W-1:0]   vga_colour,
   output logic             vga_plot,
   output logic             busy,
   output logic             frame_done,
   output logic             overrun,
   output logic             timeout_err
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
   localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);

   typedef enum logic [2:0] {
      IDLE, BG_GO, BG_WAIT, SCAN, CL_GO, CL_WAIT, DONE
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rr_q, rr_d;
   logic [PTR_W-1:0]   sel_q, sel_d;
   logic [N-1:0]       served_q, served_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic               overrun_q, overrun_d;
   logic               tout_q, tout_d;
   logic [X_W-1:0]     vga_x_q;
   logic [Y_W-1:0]     vga_y_q;
   logic [C_W-1:0]     vga_colour_q;
   logic               vga_plot_q;

   logic               scan_found;
   logic [PTR_W-1:0]   scan_pick;

   logic [X_W-1:0]     cl_x_a [N];
   logic [Y_W-1:0]     cl_y_a [N];
   logic [C_W-1:0]     cl_colour_a [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         cl_x_a[i]      = cl_x[i*X_W +: X_W];
         cl_y_a[i]      = cl_y[i*Y_W +: Y_W];
         cl_colour_a[i] = cl_colour[i*C_W +: C_W];
      end
   end

   // Circular search starting at rr_q; first live, unserved requester wins.
   always_comb begin
      scan_found = 1'b0;
      scan_pick  = '0;
      for (int k = 0; k < N; k++) begin
         int               idx;
         logic [PTR_W-1:0] ip;
         idx = int'(rr_q) + k;
         if (idx >= N) idx = idx - N;
         ip = PTR_W'(idx);
         if (!scan_found && cl_req[ip] && !served_q[ip]) begin
            scan_found = 1'b1;
            scan_pick  = ip;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      sel_d      = sel_q;
      served_d   = served_q;
      wd_d       = wd_q;
      tout_d     = tout_q;
      overrun_d  = overrun_q | (frame_tick && (state_q != IDLE));
      bg_start   = 1'b0;
      cl_start   = '0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_tick) begin
               served_d = '0;
               state_d  = BG_GO;
            end
         end
         BG_GO: begin
            bg_start = 1'b1;
            wd_d     = '0;
            state_d  = BG_WAIT;
         end
         BG_WAIT: begin
            // wd_q == 0 is the guard cycle: a stale finished level is ignored.
            if ((wd_q != '0) && bg_finished) begin
               state_d = SCAN;
            end else if (wd_q == WD_LAST) begin
               tout_d  = 1'b1;
               state_d = SCAN;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         SCAN: begin
            if (scan_found) begin
               sel_d               = scan_pick;
               served_d[scan_pick] = 1'b1;
               rr_d                = (scan_pick == PTR_LAST) ? '0 : scan_pick + 1'b1;
               state_d             = CL_GO;
            end else begin
               state_d = DONE;
            end
         end
         CL_GO: begin
            cl_start[sel_q] = 1'b1;
            wd_d            = '0;
            state_d         = CL_WAIT;
         end
         CL_WAIT: begin
            if ((wd_q != '0) && cl_finished[sel_q]) begin
               state_d = SCAN;
            end else if (wd_q == WD_LAST) begin
               tout_d  = 1'b1;
               state_d = SCAN;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         DONE: begin
            frame_done = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= IDLE;
         rr_q         <= '0;
         sel_q        <= '0;
         served_q     <= '0;
         wd_q         <= '0;
         overrun_q    <= 1'b0;
         tout_q       <= 1'b0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         sel_q     <= sel_d;
         served_q  <= served_d;
         wd_q      <= wd_d;
         overrun_q <= overrun_d;
         tout_q    <= tout_d;
         // Only the drawer currently granted can reach the frame buffer.
         if (state_q == BG_WAIT) begin
            vga_x_q      <= bg_x;
            vga_y_q      <= bg_y;
            vga_colour_q <= bg_colour;
            vga_plot_q   <= bg_plot;
         end else if (state_q == CL_WAIT) begin
            vga_x_q      <= cl_x_a[sel_q];
            vga_y_q      <= cl_y_a[sel_q];
            vga_colour_q <= cl_colour_a[sel_q];
            vga_plot_q   <= cl_plot[sel_q];
         end else begin
            vga_plot_q <= 1'b0;
         end
      end
   end

   assign busy        = (state_q != IDLE);
   assign overrun     = overrun_q;
   assign timeout_err = tout_q;
   assign vga_x       = vga_x_q;
   assign vga_y       = vga_y_q;
   assign vga_colour  = vga_colour_q;
   assign vga_plot    = vga_plot_q;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Randomized bench for frame_draw_scheduler. The reference model plans each
// frame as a timeline (start, wait window, end of every job) from the request
// mask, the round-robin pointer and the chosen drawer latencies. It then
// predicts every output cycle by cycle from that plan.
module tb_frame_draw_scheduler;
   localparam int X_W  = 8;
   localparam int Y_W  = 7;
   localparam int C_W  = 3;
   localparam int N    = 4;
   localparam int TO   = 16;
   localparam int NCYC = 6000;

   logic             clock = 1'b0;
   logic             resetn, frame_tick, bg_start, bg_finished, bg_plot;
   logic [X_W-1:0]   bg_x, vga_x;
   logic [Y_W-1:0]   bg_y, vga_y;
   logic [C_W-1:0]   bg_colour, vga_colour;
   logic [N-1:0]     cl_req, cl_start, cl_finished, cl_plot;
   logic [N*X_W-1:0] cl_x;
   logic [N*Y_W-1:0] cl_y;
   logic [N*C_W-1:0] cl_colour;
   logic             vga_plot, busy, frame_done, overrun, timeout_err;

   always #5 clock = ~clock;

   frame_draw_scheduler #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .N(N), .TIMEOUT(TO)) dut (
      .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
      .bg_start(bg_start), .bg_finished(bg_finished),
      .bg_x(bg_x), .bg_y(bg_y), .bg_colour(bg_colour), .bg_plot(bg_plot),
      .cl_req(cl_req), .cl_start(cl_start), .cl_finished(cl_finished),
      .cl_x(cl_x), .cl_y(cl_y), .cl_colour(cl_colour), .cl_plot(cl_plot),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   // Reference model: current frame plan plus scheduler-level state.
   bit   act;
   int   t0, done_c, nj, rr;
   int   who [N+1];
   int   go_c[N+1];
   int   ws_c[N+1];
   int   en_c[N+1];
   int   dly [N+1];
   bit   tmo [N+1];
   bit   m_ov, m_to;
   logic [X_W-1:0] e_x;
   logic [Y_W-1:0] e_y;
   logic [C_W-1:0] e_c;
   logic           e_p;
   int   dir_idx, next_rst;

   // Directed frames first: basic frame, round-robin 1011 then 1111, sprite timeouts.
   logic [N-1:0] dir_req[4] = '{4'b0000, 4'b1011, 4'b1111, 4'b0110};
   int           dir_dbg[4] = '{10, 3, 2, 2};
   int           dir_dcl[4] = '{1, 4, 3, 30};

   function automatic int rand_d();
      if ($urandom_range(7, 0) == 0) return int'($urandom_range(TO + 3, TO));
      return int'($urandom_range(TO - 1, 1));
   endfunction

   // Drawer latency d: finished is seen d cycles into the wait window; a job
   // ends when finished is seen (d <= TO-1) or after TO wait cycles otherwise.
   // The scheduler spends one cycle picking between jobs, so each start follows
   // the previous job's last wait cycle by two, and so does frame_done.
   task automatic build_frame(input int c, input logic [N-1:0] req, input int dbg, input int dcl);
      int t;
      act = 1'b1;
      t0  = c;
      who[0] = -1;
      dly[0] = dbg;
      nj = 1;
      for (int k = 0; k < N; k++) begin
         if (req[(rr + k) % N]) begin
            who[nj] = (rr + k) % N;
            dly[nj] = (dcl > 0) ? dcl : rand_d();
            nj++;
         end
      end
      if (nj > 1) rr = (who[nj-1] + 1) % N;
      t = c + 1;
      for (int j = 0; j < nj; j++) begin
         go_c[j] = t;
         ws_c[j] = t + 1;
         tmo[j]  = (dly[j] > TO - 1);
         en_c[j] = ws_c[j] + (tmo[j] ? TO - 1 : dly[j]);
         t = en_c[j] + 2;
      end
      done_c = t;
   endtask

   task automatic check_cycle();
      logic [N-1:0] ecl;
      logic ebg, edn, eby;
      ecl = '0; ebg = 1'b0; edn = 1'b0; eby = 1'b0;
      if (act) begin
         eby = (cyc > t0) && (cyc <= done_c);
         ebg = (cyc == go_c[0]);
         edn = (cyc == done_c);
         for (int j = 1; j < nj; j++)
            if (cyc == go_c[j]) ecl[who[j]] = 1'b1;
      end
      chk("bg_start",    32'(bg_start),    32'(ebg));
      chk("cl_start",    32'(cl_start),    32'(ecl));
      chk("frame_done",  32'(frame_done),  32'(edn));
      chk("busy",        32'(busy),        32'(eby));
      chk("overrun",     32'(overrun),     32'(m_ov));
      chk("timeout_err", 32'(timeout_err), 32'(m_to));
      chk("vga_plot",    32'(vga_plot),    32'(e_p));
      chk("vga_x",       32'(vga_x),       32'(e_x));
      chk("vga_y",       32'(vga_y),       32'(e_y));
      chk("vga_colour",  32'(vga_colour),  32'(e_c));
   endtask

   task automatic drive_cycle();
      bit by, tk;
      int wj;
      by = act && (cyc > t0) && (cyc <= done_c);
      wj = -1;
      if (act)
         for (int j = 0; j < nj; j++)
            if (cyc >= ws_c[j] && cyc <= en_c[j]) wj = j;

      bg_x        = X_W'($urandom);
      bg_y        = Y_W'($urandom);
      bg_colour   = C_W'($urandom);
      bg_plot     = 1'($urandom);
      cl_x        = (N*X_W)'({$urandom, $urandom});
      cl_y        = (N*Y_W)'({$urandom, $urandom});
      cl_colour   = (N*C_W)'($urandom);
      cl_plot     = N'($urandom);
      bg_finished = 1'($urandom);
      cl_finished = N'($urandom);

      if ((cyc >= next_rst) && (wj >= 1)) begin
         resetn     = 1'b0;
         frame_tick = 1'b0;
         act  = 1'b0;
         rr   = 0;
         m_ov = 1'b0;
         m_to = 1'b0;
         e_x  = '0; e_y = '0; e_c = '0; e_p = 1'b0;
         next_rst += 1500;
         return;
      end
      resetn = 1'b1;

      // Inside a wait window the granted drawer's finished follows its latency;
      // the first window cycle keeps random junk to exercise the guard cycle.
      if (wj >= 0 && cyc > ws_c[wj]) begin
         if (wj == 0) bg_finished = (cyc - ws_c[0] >= dly[0]);
         else cl_finished[who[wj]] = (cyc - ws_c[wj] >= dly[wj]);
      end

      if (wj == 0) begin
         e_x = bg_x; e_y = bg_y; e_c = bg_colour; e_p = bg_plot;
      end else if (wj > 0) begin
         e_x = cl_x[who[wj]*X_W +: X_W];
         e_y = cl_y[who[wj]*Y_W +: Y_W];
         e_c = cl_colour[who[wj]*C_W +: C_W];
         e_p = cl_plot[who[wj]];
      end else begin
         e_p = 1'b0;
      end
      if (wj >= 0 && cyc == en_c[wj] && tmo[wj]) m_to = 1'b1;

      // A sprite already started may drop its request without affecting the job.
      if (wj >= 1 && cyc == ws_c[wj] && $urandom_range(1, 0) == 1)
         cl_req[who[wj]] = 1'b0;

      if (!by) tk = (dir_idx < 4) ? 1'b1 : ($urandom_range(3, 0) == 0);
      else if (cyc == done_c) tk = ($urandom_range(7, 0) == 0);
      else tk = ($urandom_range(63, 0) == 0);
      frame_tick = tk;

      if (tk && !by) begin
         if (dir_idx < 4) begin
            cl_req = dir_req[dir_idx];
            build_frame(cyc, cl_req, dir_dbg[dir_idx], dir_dcl[dir_idx]);
            dir_idx++;
         end else begin
            cl_req = N'($urandom);
            build_frame(cyc, cl_req, rand_d(), -1);
         end
      end else if (tk) begin
         m_ov = 1'b1;
      end
   endtask

   initial begin
      resetn = 1'b0; frame_tick = 1'b0; cl_req = '0;
      bg_finished = 1'b0; bg_plot = 1'b0; bg_x = '0; bg_y = '0; bg_colour = '0;
      cl_finished = '0; cl_plot = '0; cl_x = '0; cl_y = '0; cl_colour = '0;
      act = 1'b0; t0 = 0; done_c = 0; nj = 0; rr = 0;
      m_ov = 1'b0; m_to = 1'b0;
      e_x = '0; e_y = '0; e_c = '0; e_p = 1'b0;
      dir_idx = 0; next_rst = 1500;
      for (cyc = 1; cyc <= NCYC; cyc++) begin
         @(posedge clock);
         #1;
         check_cycle();
         drive_cycle();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/frame_draw_scheduler.md
FRAME_DRAW_SCHEDULER -- requirements
Module: frame_draw_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning): X_W, 8, x coord width; Y_W, 7, y coord width; C_W, 3, colour width; N, 4, sprite-drawer count; TIMEOUT, 20000, max cycles per drawer job.
REQ-002 Ports SHALL be (name direction width meaning):
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse requesting a new frame
- bg_start  out  1  one-cycle start pulse to background drawer
- bg_finished  in  1  background drawer done (level)
- bg_x / bg_y / bg_colour / bg_plot  in  X_W/Y_W/C_W/1  background pixel stream
- cl_req  in  N  per-sprite draw request (level)
- cl_start  out  N  one-hot one-cycle start pulse to sprite drawer
- cl_finished  in  N  per-sprite done (level)
- cl_x / cl_y / cl_colour  in  N*X_W/N*Y_W/N*C_W  packed pixel streams, index i at [i*W +: W]
- cl_plot  in  N  per-sprite plot strobe
- vga_x / vga_y / vga_colour / vga_plot  out  X_W/Y_W/C_W/1  registered pixel port to frame buffer
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- overrun  out  1  sticky: frame_tick arrived while busy
- timeout_err  out  1  sticky: a drawer job was aborted

Function
REQ-003 FSM states SHALL be IDLE, BG_GO, BG_WAIT, SCAN, CL_GO, CL_WAIT, DONE.
REQ-004 IDLE: frame_tick=1 -> BG_GO, clear served mask, rr_ptr unchanged.
REQ-005 BG_GO: assert bg_start one cycle, clear watchdog, -> BG_WAIT.
REQ-006 BG_WAIT: first cycle ignores bg_finished (guard cycle); thereafter bg_finished=1 -> SCAN.
REQ-007 SCAN (one cycle): select lowest i in circular order from rr_ptr with cl_req[i]=1 and served[i]=0; found -> latch sel=i, set served[i], rr_ptr<=(i+1) mod N, -> CL_GO; none -> DONE.
REQ-008 CL_GO: assert cl_start[sel] one cycle, clear watchdog, -> CL_WAIT.
REQ-009 CL_WAIT: same guard-cycle rule as BG_WAIT on cl_finished[sel]; done -> SCAN.
REQ-010 DONE: pulse frame_done one cycle, -> IDLE.
REQ-011 Each requester SHALL be served at most once per frame; request deasserted before SCAN is skipped; request dropped mid-job does not abort the job.
REQ-012 Watchdog SHALL count cycles in BG_WAIT/CL_WAIT; on reaching TIMEOUT-1 without finish: set timeout_err, advance as if finished (BG_WAIT->SCAN, CL_WAIT->SCAN).
REQ-013 Pixel mux SHALL register one cycle: in BG_WAIT vga_* <= bg_*; in CL_WAIT vga_* <= cl_*[sel]; all other states vga_plot<=0, x/y/colour hold.
REQ-014 Pixel latency SHALL be exactly 1 cycle from source input to vga_* output; no pixel from a non-granted source ever reaches vga_plot=1.
REQ-015 frame_tick while busy SHALL set overrun and be dropped (no queued frame); tick in the same cycle as DONE is also dropped.
REQ-016 Watchdog SHALL be wide enough for TIMEOUT (clog2); rr_ptr width clog2(N), wrap N-1 -> 0.

Reset
REQ-017 resetn=0 at a clock edge SHALL force: state IDLE, rr_ptr 0, served 0, watchdog 0, bg_start 0, cl_start 0, vga_x/y/colour 0, vga_plot 0, busy 0, frame_done 0, overrun 0, timeout_err 0.
REQ-018 Reset mid-frame SHALL abandon the job immediately; no start pulse issued in the reset cycle or the following one.
REQ-019 Sticky flags SHALL clear only by reset.

Verification
REQ-020 Basic frame: tick, bg_finished after 10 cycles, cl_req=0 -> bg_start pulse cycle 1, frame_done ~13 cycles after tick, no cl_start.
REQ-021 Round-robin: cl_req=4'b1011, rr_ptr=0 -> cl_start order 0,1,3; next frame with cl_req=4'b1111 -> order 0,1,2,3 (rr_ptr=0 after wrap from 3).
REQ-022 Mux: during sprite 2 job, cl_plot[2]=1 with x=0x55,y=0x2A,colour=3'b101, sprite 0 plot=1 -> next cycle vga=0x55/0x2A/101 plot 1; sprite 0 pixels never appear.
REQ-023 Timeout: TIMEOUT=16, cl_finished[1] held 0 -> abort after 16 CL_WAIT cycles, timeout_err=1, next requester started.
REQ-024 Overrun: tick while BG_WAIT -> overrun=1, exactly one frame_done emitted.
REQ-025 Reset in CL_WAIT -> next cycle all outputs at REQ-017 values, busy=0.
